sr_iter: RTL and testbench

- Iterative shift-right unit for the 16-bit datapath; the opposite direction to the existing combinational shift-left-by-1 block.
- Performs a logical or arithmetic right shift by 0–15 positions, one bit per clock.
- Uses a START/BUSY/DONE handshake so the multicycle control unit can sequence SRL/SRA instructions.
- Sits beside the ALU; the result is muxed onto the ALU output bus.

---
 rtl/sr_pkg.sv | 20 ++
 rtl/sr_step.sv | 26 ++
 rtl/sr_iter.sv | 103 ++++++++++
 tb/tb_sr_iter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the iterative shift-right unit: FSM states,
// default widths and the fill-mode encoding used by the one-bit step.
package sr_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int SHAMT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t LOGICAL    = 2'd0;
    localparam mode_t ARITHMETIC = 2'd1;
    localparam mode_t ROTATE     = 2'd2;

endpackage

// File: rtl/sr_step.sv
// One-bit right step: shifts the vector right by one and inserts the fill
// bit chosen by the mode (zero, sign bit, or the bit shifted out).
module sr_step
    import sr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  mode_t            mode,
    output logic [WIDTH-1:0] result
);

    logic fill;

    // Select the fill bit for the vacated MSB position.
    always_comb begin
        fill = 1'b0;
        case (mode)
            ARITHMETIC: fill = data[WIDTH-1];
            ROTATE:     fill = data[0];
            default:    fill = 1'b0;
        endcase
        result = {fill, data[WIDTH-1:1]};
    end

endmodule

// File: rtl/sr_iter.sv
// Iterative shift-right unit, one bit per clock, with START/BUSY/DONE
// handshake. Optional rotate-right mode enabled by SR_ITER_ROTATE_EN,
// which adds the ROT input (ROT overrides ARITH).
module sr_iter
    import sr_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ARITH,
`ifdef SR_ITER_ROTATE_EN
    input  logic               ROT,
`endif
    input  logic [SHAMT_W-1:0] SHAMT,
    input  logic [WIDTH-1:0]   INPUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH-1:0]   OUTPUT
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] count;
    mode_t              mode;
    mode_t              mode_sel;
    logic               accept;

    // A new request is taken whenever no shift is in flight (IDLE or FIN).
    assign accept = START && (state != SHIFT);

    // Decode the requested fill mode from the request inputs.
    always_comb begin
        mode_sel = ARITH ? ARITHMETIC : LOGICAL;
`ifdef SR_ITER_ROTATE_EN
        if (ROT) begin
            mode_sel = ROTATE;
        end
`endif
    end

    sr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data   (shreg),
        .mode   (mode),
        .result (step_out)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; FIN lasts exactly one cycle unless re-started.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FIN: begin
                if (START) begin
                    state_next = (SHAMT != '0) ? SHIFT : FIN;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    state_next = FIN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and per-cycle shift; the register holds once shifting ends.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shreg <= '0;
            count <= '0;
            mode  <= LOGICAL;
        end else if (accept) begin
            shreg <= INPUT;
            count <= SHAMT;
            mode  <= mode_sel;
        end else if (state == SHIFT) begin
            shreg <= step_out;
            count <= count - 1'b1;
        end
    end

    assign BUSY   = (state == SHIFT);
    assign DONE   = (state == FIN);
    assign OUTPUT = shreg;

endmodule

// File: tb/tb_sr_iter.sv
// Self-checking bench for sr_iter: a cycle-count reference model predicts
// BUSY/DONE/OUTPUT every cycle, directed cases pin literal results and
// latencies, and a random phase exercises overlapping and ignored starts.
module tb_sr_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        arith = 1'b0;
    logic        rot = 1'b0;
    logic [3:0]  shamt = 4'd0;
    logic [15:0] din = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    bit          active = 1'b0;
    int          done_edge = 0;
    logic [15:0] exp_val = 16'd0;
    logic [15:0] prev_val = 16'd0;

    sr_iter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .START   (start),
        .ARITH   (arith),
`ifdef SR_ITER_ROTATE_EN
        .ROT     (rot),
`endif
        .SHAMT   (shamt),
        .INPUT   (din),
        .BUSY    (busy),
        .DONE    (done),
        .OUTPUT  (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_shift(logic [15:0] v, int sh, bit ar, bit rt);
        logic signed [15:0] s;
        logic [31:0] w;
        s = v;
`ifdef SR_ITER_ROTATE_EN
        if (rt) begin
            w = ({16'd0, v} >> sh) | ({16'd0, v} << (16 - sh));
            return w[15:0];
        end
`else
        if (rt) begin
            w = 32'd0;
        end
`endif
        if (ar) return s >>> sh;
        return v >> sh;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: an op accepted at edge T completes at edge T+SHAMT;
    // a new request is only taken once the previous one has completed.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            active   = 1'b0;
            exp_val  = 16'd0;
            prev_val = 16'd0;
        end else if (start && (!active || cyc > done_edge)) begin
            if (active) prev_val = exp_val;
            active    = 1'b1;
            done_edge = cyc + int'(shamt);
            exp_val   = ref_shift(din, int'(shamt), arith, rot);
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
            chk("reset_out", dout, 0);
        end else begin
            chk("busy", busy, (active && cyc < done_edge));
            chk("done", done, (active && cyc == done_edge));
            if (!(active && cyc < done_edge))
                chk("out", dout, active ? exp_val : prev_val);
        end
    end

    task automatic issue(logic [15:0] v, logic [3:0] sh, bit ar, bit rt, output int t);
        #1;
        start = 1'b1;
        din   = v;
        shamt = sh;
        arith = ar;
        rot   = rt;
        @(negedge clk);
        t = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int t, int lat, logic [15:0] req, string name);
        int k;
        for (k = 0; k < 40; k++) begin
            if (done) break;
            @(negedge clk);
        end
        #1;
        if (k == 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            chk({name, "_out"}, dout, req);
            chk({name, "_lat"}, cyc - t, lat);
        end
    endtask

    initial begin
        int t0;
        int t1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // model pinning against hand-computed literals
        chk("ref_srl1", ref_shift(16'h9992, 1, 0, 0), 16'h4CC9);
        chk("ref_sra4", ref_shift(16'h9992, 4, 1, 0), 16'hF999);
        chk("ref_sra15", ref_shift(16'h8000, 15, 1, 0), 16'hFFFF);

        issue(16'h9992, 4'd1, 0, 0, t0);  wait_done(t0, 1, 16'h4CC9, "srl1");
        issue(16'h9992, 4'd4, 1, 0, t0);  wait_done(t0, 4, 16'hF999, "sra4");
        issue(16'h9992, 4'd4, 0, 0, t0);  wait_done(t0, 4, 16'h0999, "srl4");
        issue(16'h1082, 4'd0, 0, 0, t0);  wait_done(t0, 0, 16'h1082, "sh0");
        issue(16'h8000, 4'd15, 0, 0, t0); wait_done(t0, 15, 16'h0001, "srl15");
        issue(16'h8000, 4'd15, 1, 0, t0); wait_done(t0, 15, 16'hFFFF, "sra15");

        // start while busy is ignored, then back-to-back start in FIN
        issue(16'h7BF6, 4'd3, 0, 0, t0);
        @(negedge clk);
        issue(16'hFFFF, 4'd1, 1, 0, t1);
        wait_done(t0, 3, 16'h0F7E, "busy_ign");
        issue(16'h9992, 4'd4, 1, 0, t0);  wait_done(t0, 4, 16'hF999, "b2b");
        repeat (2) @(negedge clk);

        // reset mid-shift
        issue(16'hABCD, 4'd8, 1, 0, t0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_now_out", dout, 0);
        chk("rst_now_busy", busy, 0);
        chk("rst_now_done", done, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0010, 4'd4, 0, 0, t0);  wait_done(t0, 4, 16'h0001, "post_rst");

`ifdef SR_ITER_ROTATE_EN
        issue(16'h0001, 4'd1, 0, 1, t0);  wait_done(t0, 1, 16'h8000, "rot1");
        issue(16'h1234, 4'd4, 1, 1, t0);  wait_done(t0, 4, 16'h4123, "rot4");
`endif

        // random phase: starts arrive freely, including while busy
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            #1;
            start = ($urandom_range(0, 2) == 0);
            din   = 16'($urandom);
            shamt = 4'($urandom_range(0, 15));
            arith = 1'($urandom);
`ifdef SR_ITER_ROTATE_EN
            rot   = ($urandom_range(0, 3) == 0);
`endif
        end
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
